// File: rtl/svsim_stim_sequencer.sv
// svsim_stim_sequencer: queues {channel, value, delay} commands from a host and,
// one at a time, waits the requested number of idle cycles before writing the
// value onto the selected channel of a held drive bus.
// Optional feature: define SVSIM_STIM_TIMESTAMP_EN to add a free-running cycle
// counter and the applied_time port that records when each APPLY happened.
module svsim_stim_sequencer #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 8,
    parameter int DELAY_W  = 16,
    localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [CW-1:0]             cmd_chan,
    input  logic [WIDTH-1:0]          cmd_value,
    input  logic [DELAY_W-1:0]        cmd_delay,
    input  logic                      flush,
    output logic [CHANNELS*WIDTH-1:0] drive,
    output logic                      applied_valid,
    output logic [CW-1:0]             applied_chan,
    output logic                      busy,
    output logic [AW:0]               fifo_count,
    output logic                      err_chan
`ifdef SVSIM_STIM_TIMESTAMP_EN
    ,
    output logic [63:0]               applied_time
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_APPLY = 2'd2
    } state_t;

    localparam logic [CW:0]      CH_LIMIT = (CW + 1)'(CHANNELS);
    localparam logic [AW:0]      FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]      ONE_CNT  = (AW + 1)'(1);
    localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
    localparam logic [DELAY_W-1:0] DLY_ONE = DELAY_W'(1);

    // Command storage (data only, never reset)
    logic [CW-1:0]      fifo_chan_q  [DEPTH];
    logic [WIDTH-1:0]   fifo_value_q [DEPTH];
    logic [DELAY_W-1:0] fifo_delay_q [DEPTH];

    logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [AW:0]        count_q, count_d;
    logic               push, pop, empty, full, head_ok, enter_apply;

    state_t             state_q;
    logic [DELAY_W-1:0] delay_q;
    logic [CW-1:0]      cur_chan_q;
    logic [WIDTH-1:0]   cur_value_q;
    logic               cur_ok_q;
    logic               applied_valid_q;
    logic [CW-1:0]      applied_chan_q;
    logic [CHANNELS*WIDTH-1:0] drive_q;
    logic               err_q;

    // Handshake, pop decision and occupancy bookkeeping
    always_comb begin
        empty     = (count_q == '0);
        full      = (count_q == FULL_CNT);
        // No bypass: a full FIFO refuses even if the head is leaving this cycle.
        cmd_ready = !full && !flush && !reset;
        push      = cmd_valid && cmd_ready;
        pop       = (state_q == S_IDLE) && !empty && !flush && !reset;
        head_ok   = ({1'b0, fifo_chan_q[rd_ptr_q]} < CH_LIMIT);
        count_d   = count_q;
        if (push && !pop) begin
            count_d = count_q + ONE_CNT;
        end else if (!push && pop) begin
            count_d = count_q - ONE_CNT;
        end
        enter_apply = !reset && !flush &&
                      ((pop && (fifo_delay_q[rd_ptr_q] == '0)) ||
                       ((state_q == S_WAIT) && (delay_q == DLY_ONE)));
    end

    // FIFO storage write port
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_chan_q[wr_ptr_q]  <= cmd_chan;
            fifo_value_q[wr_ptr_q] <= cmd_value;
            fifo_delay_q[wr_ptr_q] <= cmd_delay;
        end
    end

    // FIFO pointers and count; flush empties the queue like reset does
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            count_q <= count_d;
        end
    end

    // Sequencing FSM: IDLE pops, WAIT counts the delay, APPLY writes the channel
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= S_IDLE;
            delay_q         <= '0;
            applied_valid_q <= 1'b0;
            applied_chan_q  <= '0;
            drive_q         <= '0;
            err_q           <= 1'b0;
        end else if (flush) begin
            // Drop anything in flight; drive and the error flag are kept.
            state_q         <= S_IDLE;
            delay_q         <= '0;
            applied_valid_q <= 1'b0;
            applied_chan_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    applied_valid_q <= 1'b0;
                    applied_chan_q  <= '0;
                    if (pop) begin
                        cur_chan_q  <= fifo_chan_q[rd_ptr_q];
                        cur_value_q <= fifo_value_q[rd_ptr_q];
                        cur_ok_q    <= head_ok;
                        if (fifo_delay_q[rd_ptr_q] == '0) begin
                            state_q         <= S_APPLY;
                            applied_valid_q <= head_ok;
                            applied_chan_q  <= head_ok ? fifo_chan_q[rd_ptr_q] : '0;
                        end else begin
                            delay_q <= fifo_delay_q[rd_ptr_q];
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    delay_q <= delay_q - DLY_ONE;
                    if (delay_q == DLY_ONE) begin
                        state_q         <= S_APPLY;
                        applied_valid_q <= cur_ok_q;
                        applied_chan_q  <= cur_ok_q ? cur_chan_q : '0;
                    end
                end
                S_APPLY: begin
                    state_q         <= S_IDLE;
                    applied_valid_q <= 1'b0;
                    applied_chan_q  <= '0;
                    if (cur_ok_q) begin
                        for (int k = 0; k < CHANNELS; k++) begin
                            if (cur_chan_q == CW'(k)) begin
                                drive_q[k*WIDTH +: WIDTH] <= cur_value_q;
                            end
                        end
                    end else begin
                        err_q <= 1'b1;
                    end
                end
                default: begin
                    state_q         <= S_IDLE;
                    applied_valid_q <= 1'b0;
                    applied_chan_q  <= '0;
                end
            endcase
        end
    end

`ifdef SVSIM_STIM_TIMESTAMP_EN
    logic [63:0] ts_q;
    logic [63:0] time_q;

    // Free-running cycle counter; the APPLY cycle's count is latched and held
    always_ff @(posedge clock) begin
        if (reset) begin
            ts_q   <= '0;
            time_q <= '0;
        end else begin
            ts_q <= ts_q + 64'd1;
            if (enter_apply) begin
                time_q <= ts_q + 64'd1;
            end
        end
    end

    assign applied_time = time_q;
`endif

    assign drive         = drive_q;
    assign applied_valid = applied_valid_q;
    assign applied_chan  = applied_chan_q;
    assign busy          = (state_q != S_IDLE) || !empty;
    assign fifo_count    = count_q;
    assign err_chan      = err_q;

endmodule

// File: tb/tb_svsim_stim_sequencer.sv
// Bench for svsim_stim_sequencer. Five channels are used so that a 3-bit channel
// index can name channels that do not exist (with four channels every 2-bit
// index is legal). Expected apply cycles, drive contents, occupancy and flags
// come from a queue-based model of accepted commands.
module tb_svsim_stim_sequencer;

    localparam int CH  = 5;
    localparam int W   = 32;
    localparam int DEP = 8;
    localparam int DW  = 16;
    localparam int CW  = 3;
    localparam int AW  = 3;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [CW-1:0]     cmd_chan = '0;
    logic [W-1:0]      cmd_value = '0;
    logic [DW-1:0]     cmd_delay = '0;
    logic              flush = 1'b0;
    logic [CH*W-1:0]   drive;
    logic              applied_valid;
    logic [CW-1:0]     applied_chan;
    logic              busy;
    logic [AW:0]       fifo_count;
    logic              err_chan;
`ifdef SVSIM_STIM_TIMESTAMP_EN
    logic [63:0]       applied_time;
`endif

    svsim_stim_sequencer #(
        .CHANNELS(CH), .WIDTH(W), .DEPTH(DEP), .DELAY_W(DW)
    ) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_chan(cmd_chan), .cmd_value(cmd_value), .cmd_delay(cmd_delay),
        .flush(flush), .drive(drive),
        .applied_valid(applied_valid), .applied_chan(applied_chan),
        .busy(busy), .fifo_count(fifo_count), .err_chan(err_chan)
`ifdef SVSIM_STIM_TIMESTAMP_EN
        , .applied_time(applied_time)
`endif
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // One accepted command: acceptance, pop and apply cycles plus payload.
    typedef struct {
        int         acc;
        int         pop;
        int         apply;
        int         chan;
        logic [W-1:0] val;
        bit         ok;
    } item_t;

    item_t        exp_q[$];
    logic [W-1:0] mdrive [CH];
    bit           merr;
    int           last_apply;
    int           rel0;
    bit           mon_en = 1'b0;
    int           errors = 0;
    int           checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic void model_clear(input bit hard);
        exp_q.delete();
        last_apply = -1000;
        if (hard) begin
            merr = 1'b0;
            for (int k = 0; k < CH; k++) mdrive[k] = '0;
        end
    endfunction

    // Per-cycle comparison of every observable output against the model.
    task automatic check_cycle();
        int    c;
        int    n_fifo;
        bit    b;
        item_t it;
        c = cyc;
        n_fifo = 0;
        b = 1'b0;
        for (int k = 0; k < CH; k++) begin
            chk($sformatf("drive[%0d]", k), 64'(drive[k*W +: W]), 64'(mdrive[k]));
        end
        chk("err_chan", 64'(err_chan), 64'(merr));
        foreach (exp_q[i]) begin
            if (exp_q[i].acc < c && c <= exp_q[i].pop) n_fifo++;
            if (exp_q[i].acc < c) b = 1'b1;
        end
        chk("fifo_count", 64'(fifo_count), 64'(n_fifo));
        chk("busy", 64'(busy), 64'(b));
        chk("cmd_ready", 64'(cmd_ready), 64'(!reset && !flush && (n_fifo < DEP)));
        if (exp_q.size() != 0 && exp_q[0].apply == c) begin
            it = exp_q.pop_front();
            if (it.ok) begin
                chk("applied_valid", 64'(applied_valid), 64'd1);
                chk("applied_chan", 64'(applied_chan), 64'(it.chan));
`ifdef SVSIM_STIM_TIMESTAMP_EN
                chk("applied_time", applied_time, 64'(c - rel0));
`endif
                if (!flush && !reset) mdrive[it.chan] = it.val;
            end else begin
                chk("applied_valid_badchan", 64'(applied_valid), 64'd0);
                if (!flush && !reset) merr = 1'b1;
            end
        end else begin
            chk("applied_valid_idle", 64'(applied_valid), 64'd0);
            chk("applied_chan_idle", 64'(applied_chan), 64'd0);
        end
    endtask

    initial begin : monitor
        forever begin
            @(negedge clock);
            #2;
            if (mon_en) check_cycle();
        end
    end

    task automatic push_cmd(input int ch, input logic [W-1:0] v, input int d);
        int    waited;
        item_t it;
        waited = 0;
        @(negedge clock);
        cmd_valid = 1'b1;
        cmd_chan  = CW'(ch);
        cmd_value = v;
        cmd_delay = DW'(d);
        #1;
        while (!cmd_ready && waited < 300) begin
            @(negedge clock);
            #1;
            waited++;
        end
        if (!cmd_ready) begin
            chk("push_ready_timeout", 64'(cmd_ready), 64'd1);
            cmd_valid = 1'b0;
            return;
        end
        it.acc   = cyc;
        it.pop   = (cyc + 1 > last_apply + 1) ? cyc + 1 : last_apply + 1;
        it.apply = it.pop + d + 1;
        it.chan  = ch;
        it.val   = v;
        it.ok    = (ch < CH);
        last_apply = it.apply;
        exp_q.push_back(it);
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drain(input int bound);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            @(negedge clock);
            n++;
        end
        chk("drain_remaining", 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge clock);
    endtask

    task automatic flush_pulse();
        @(negedge clock);
        flush = 1'b1;
        @(posedge clock);
        #1;
        model_clear(1'b0);
        flush = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        model_clear(1'b1);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        rel0 = cyc;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        model_clear(1'b1);
        mon_en = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        rel0 = cyc;

        // Immediate apply and delayed apply
        push_cmd(2, 32'hDEADBEEF, 0);
        wait_drain(50);
        push_cmd(1, 32'h5, 3);
        wait_drain(50);

        // Long wait fills the FIFO; ninth push waits for the first pop
        push_cmd(3, 32'h1111_2222, 100);
        repeat (3) @(negedge clock);
        for (int i = 0; i < 9; i++) begin
            push_cmd(i % CH, $urandom, int'($urandom_range(0, 2)));
        end
        wait_drain(400);

        // Nonexistent channels
        push_cmd(7, 32'h0BAD_0BAD, 0);
        push_cmd(6, 32'h0BAD_0006, 2);
        push_cmd(0, 32'hA5A5_A5A5, 0);
        wait_drain(50);

        // Flush during the first command's wait, then resume
        push_cmd(4, 32'h4444_4444, 20);
        push_cmd(0, 32'h0000_0001, 0);
        push_cmd(1, 32'h0000_0002, 1);
        repeat (6) @(negedge clock);
        flush_pulse();
        repeat (2) @(negedge clock);
        push_cmd(2, 32'h2222_0000, 0);
        push_cmd(3, 32'h3333_0000, 1);
        wait_drain(50);

        // Reset in the middle of a wait aborts the command
        push_cmd(1, 32'hFEED_F00D, 10);
        repeat (5) @(negedge clock);
        do_reset();

        // Push ten cycles after reset release
        repeat (9) @(negedge clock);
        push_cmd(2, 32'h1234_5678, 0);
        wait_drain(50);

        // Randomized traffic with occasional flushes
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 29) == 0) begin
                flush_pulse();
            end else begin
                repeat ($urandom_range(0, 2)) @(negedge clock);
                push_cmd(int'($urandom_range(0, 7)), $urandom,
                         ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : 0);
            end
        end
        wait_drain(500);

        repeat (3) @(negedge clock);
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
